// File: rtl/sram_port_arb.sv
// Round-robin arbiter sharing one SRAM port among N_MASTERS requesters, with a
// tag FIFO that routes read responses back to the issuing master in the same cycle.
module sram_port_arb #(
  parameter int N_MASTERS = 2,
  parameter int ADDR_W    = 13,
  parameter int DATA_W    = 32,
  parameter int TAG_DEPTH = 2
) (
  input  logic                            clk_i,
  input  logic                            arst_i,
  input  logic                            cke_i,
  input  logic [N_MASTERS-1:0]            m_avalid_i,
  input  logic [N_MASTERS*ADDR_W-1:0]     m_addr_i,
  input  logic [N_MASTERS*DATA_W-1:0]     m_wdata_i,
  input  logic [N_MASTERS*(DATA_W/8)-1:0] m_wstrb_i,
  output logic [N_MASTERS-1:0]            m_ready_o,
  output logic [N_MASTERS*DATA_W-1:0]     m_rdata_o,
  output logic [N_MASTERS-1:0]            m_rvalid_o,
  output logic                            s_avalid_o,
  output logic [ADDR_W-1:0]               s_addr_o,
  output logic [DATA_W-1:0]               s_wdata_o,
  output logic [DATA_W/8-1:0]             s_wstrb_o,
  input  logic                            s_ready_i,
  input  logic                            s_rvalid_i,
  input  logic [DATA_W-1:0]               s_rdata_i,
  output logic                            err_o
);

  localparam int STRB_W = DATA_W / 8;
  localparam int IDX_W  = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam int PTR_W  = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int CNT_W  = $clog2(TAG_DEPTH + 1);

  typedef enum logic {IDLE, HOLD} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] holdIdx_q, holdIdx_d;
  logic [IDX_W-1:0] rrPtr_q, rrPtr_d;
  logic [IDX_W-1:0] tagMem_q [TAG_DEPTH];
  logic [IDX_W-1:0] tagMem_d [TAG_DEPTH];
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [DATA_W-1:0] rdata_q [N_MASTERS];
  logic [DATA_W-1:0] rdata_d [N_MASTERS];
  logic             err_q, err_d;

  logic             live, anyGnt, gntRead, tagEmpty, tagFull, block, xfer, push, pop;
  logic [IDX_W-1:0] gntIdx, cand, headIdx;

  function automatic logic [IDX_W-1:0] nextIdx(input logic [IDX_W-1:0] idx);
    return (int'(idx) == N_MASTERS - 1) ? '0 : idx + 1'b1;
  endfunction

  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] ptr);
    return (int'(ptr) == TAG_DEPTH - 1) ? '0 : ptr + 1'b1;
  endfunction

  always_comb begin
    live     = arst_i & cke_i;
    anyGnt   = 1'b0;
    gntIdx   = '0;
    cand     = rrPtr_q;
    // A stalled master keeps the port until it transfers or withdraws.
    if (state_q == HOLD && m_avalid_i[holdIdx_q]) begin
      anyGnt = 1'b1;
      gntIdx = holdIdx_q;
    end else begin
      for (int i = 0; i < N_MASTERS; i++) begin
        if (!anyGnt && m_avalid_i[cand]) begin
          anyGnt = 1'b1;
          gntIdx = cand;
        end
        cand = nextIdx(cand);
      end
    end

    gntRead  = ~|m_wstrb_i[int'(gntIdx)*STRB_W +: STRB_W];
    tagEmpty = (count_q == '0);
    tagFull  = (count_q == CNT_W'(TAG_DEPTH));
    headIdx  = tagMem_q[rdPtr_q];
    // A same-cycle response frees a tag, so a full FIFO only blocks without one.
    block    = tagFull & gntRead & ~s_rvalid_i;
    xfer     = live & anyGnt & s_ready_i & ~block;
    push     = xfer & gntRead;
    pop      = live & s_rvalid_i & ~tagEmpty;

    m_ready_o = '0;
    if (xfer) m_ready_o[gntIdx] = 1'b1;
    s_avalid_o = live & anyGnt;
    s_addr_o   = anyGnt ? m_addr_i[int'(gntIdx)*ADDR_W +: ADDR_W] : '0;
    s_wdata_o  = anyGnt ? m_wdata_i[int'(gntIdx)*DATA_W +: DATA_W] : '0;
    s_wstrb_o  = anyGnt ? m_wstrb_i[int'(gntIdx)*STRB_W +: STRB_W] : '0;

    m_rvalid_o = '0;
    if (pop) m_rvalid_o[headIdx] = 1'b1;
    m_rdata_o = '0;
    for (int k = 0; k < N_MASTERS; k++) begin
      m_rdata_o[k*DATA_W +: DATA_W] = (pop && int'(headIdx) == k) ? s_rdata_i : rdata_q[k];
    end

    state_d   = (anyGnt && !xfer) ? HOLD : IDLE;
    holdIdx_d = (anyGnt && !xfer) ? gntIdx : holdIdx_q;
    rrPtr_d   = xfer ? nextIdx(gntIdx) : rrPtr_q;
    tagMem_d  = tagMem_q;
    wrPtr_d   = wrPtr_q;
    rdPtr_d   = rdPtr_q;
    rdata_d   = rdata_q;
    if (push) begin
      tagMem_d[wrPtr_q] = gntIdx;
      wrPtr_d           = nextPtr(wrPtr_q);
    end
    if (pop) begin
      rdPtr_d          = nextPtr(rdPtr_q);
      rdata_d[headIdx] = s_rdata_i;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    err_d = err_q | (live & s_rvalid_i & tagEmpty);
  end

  assign err_o = err_q;

  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) begin
      state_q   <= IDLE;
      holdIdx_q <= '0;
      rrPtr_q   <= '0;
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      count_q   <= '0;
      err_q     <= 1'b0;
      for (int i = 0; i < TAG_DEPTH; i++) tagMem_q[i] <= '0;
      for (int k = 0; k < N_MASTERS; k++) rdata_q[k] <= '0;
    end else if (cke_i) begin
      state_q   <= state_d;
      holdIdx_q <= holdIdx_d;
      rrPtr_q   <= rrPtr_d;
      wrPtr_q   <= wrPtr_d;
      rdPtr_q   <= rdPtr_d;
      count_q   <= count_d;
      err_q     <= err_d;
      for (int i = 0; i < TAG_DEPTH; i++) tagMem_q[i] <= tagMem_d[i];
      for (int k = 0; k < N_MASTERS; k++) rdata_q[k] <= rdata_d[k];
    end
  end

endmodule

// File: doc/sram_port_arb.md
SRAM_PORT_ARB -- requirements
Module: sram_port_arb

Interface
REQ-001 SHALL have parameter N_MASTERS, default 2, meaning number of requesters sharing the port (2..4).
REQ-002 SHALL have parameter ADDR_W, default 13, meaning SRAM word address width.
REQ-003 SHALL have parameter DATA_W, default 32, meaning data width; strobe width is DATA_W/8.
REQ-004 SHALL have parameter TAG_DEPTH, default 2, meaning number of outstanding reads tracked (power of 2).
REQ-005 SHALL use one clock and an asynchronous active-low reset, with ports as listed in REQ-006..REQ-007.
REQ-006 clk_i  input  1  clock; all state on rising edge.
REQ-007 arst_i  input  1  asynchronous reset, active-low.
REQ-008 cke_i  input  1  clock enable; low freezes all state.
REQ-009 m_avalid_i  input  N_MASTERS  per-master request valid.
REQ-010 m_addr_i  input  N_MASTERS*ADDR_W  per-master word address; master k at [k*ADDR_W +: ADDR_W].
REQ-011 m_wdata_i  input  N_MASTERS*DATA_W  per-master write data.
REQ-012 m_wstrb_i  input  N_MASTERS*DATA_W/8  per-master byte strobes; all-zero means read.
REQ-013 m_ready_o  output  N_MASTERS  per-master request accepted.
REQ-014 m_rdata_o  output  N_MASTERS*DATA_W  per-master read data.
REQ-015 m_rvalid_o  output  N_MASTERS  per-master read data valid.
REQ-016 s_avalid_o, s_addr_o, s_wdata_o, s_wstrb_o  output  1/ADDR_W/DATA_W/DATA_W/8  request to SRAM port.
REQ-017 s_ready_i, s_rvalid_i, s_rdata_i  input  1/1/DATA_W  SRAM port response.
REQ-018 err_o  output  1  sticky protocol error flag.

Function
REQ-019 Transfer on master k SHALL occur when m_avalid_i[k] and m_ready_o[k] are both high in a cycle with cke_i high.
REQ-020 Grant SHALL be combinational in the request cycle: one-hot among requesting masters, round-robin starting at pointer rr_ptr.
REQ-021 s_* request fields SHALL be the granted master's fields; s_avalid_o SHALL be 0 when no grant.
REQ-022 m_ready_o[k] SHALL equal grant[k] & s_ready_i & ~block, where block = tag FIFO full & granted request is a read & ~s_rvalid_i.
REQ-023 FSM states IDLE, HOLD: IDLE->HOLD when granted master's avalid is high but no transfer; HOLD keeps grant fixed on that master until it transfers or drops avalid, then ->IDLE.
REQ-024 After each transfer rr_ptr SHALL become (granted index+1) mod N_MASTERS; otherwise unchanged.
REQ-025 Each accepted read SHALL push the master index into a FIFO of TAG_DEPTH entries; writes SHALL NOT push and produce no rvalid.
REQ-026 On s_rvalid_i high, FIFO head SHALL pop; m_rvalid_o[head] SHALL be high that same cycle with m_rdata_o[head] = s_rdata_i.
REQ-027 m_rdata_o of non-selected masters SHALL hold their last value; m_rvalid_o SHALL be one-hot or zero.
REQ-028 Simultaneous push and pop SHALL be legal at any occupancy including full; occupancy unchanged.
REQ-029 s_rvalid_i with FIFO empty SHALL be ignored for routing and SHALL set err_o until reset.
REQ-030 Read-to-rvalid latency through the block SHALL add zero cycles to the SRAM latency.
REQ-031 With cke_i low, m_ready_o and s_avalid_o SHALL be 0 and no state SHALL change.

Reset
REQ-032 On arst_i low, asynchronously: rr_ptr=0, state=IDLE, FIFO empty, m_rvalid_o=0, m_rdata_o=0, err_o=0.
REQ-033 Reset mid-transaction SHALL discard outstanding tags; responses arriving after reset release SHALL set err_o.
REQ-034 m_ready_o and s_avalid_o SHALL be 0 while arst_i is low.

Verification
REQ-035 Masters 0 and 1 both read continuously, s_ready_i=1, SRAM latency 1 -> grants alternate 0,1,0,1; each rvalid lands on issuing master one cycle after its transfer.
REQ-036 Master 1 writes addr 0x10 data 0xDEADBEEF wstrb 0xF while master 0 idle -> s_addr_o=0x10, m_ready_o=2'b10, no rvalid generated.
REQ-037 Master 0 requests with s_ready_i low 3 cycles while master 1 requests -> grant stays on 0 (HOLD) until transfer, then master 1 served next.
REQ-038 TAG_DEPTH=2, SRAM withholds rvalid, 3 reads issued -> third blocked (ready 0) until an rvalid pops a tag; same-cycle pop+push accepted.
REQ-039 s_rvalid_i pulse with no outstanding read -> err_o=1 and stays 1; all m_rvalid_o stay 0.
REQ-040 arst_i low with 2 reads outstanding -> FIFO empty, rr_ptr=0, outputs 0; late rvalid after release sets err_o.
